// File: rtl/bus_ram_responder.sv
// Word-addressed 32-bit RAM behind a four-phase request/ready handshake.
// Latency: o_ready rises WAIT_STATES+2 edges after the edge that samples the request.
// Backpressure: DONE holds o_ready/o_data until i_request drops; dropping it during WAIT aborts.
module bus_ram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_ready,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_t                  state;
    logic [3:0]              cnt;
    logic                    rw_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [31:0]             wdat_q;
    logic [31:0]             mem [DEPTH];
    logic                    access_now;
    logic                    unused_addr;

    assign unused_addr = ^{i_address[31:ADDR_WIDTH+2], i_address[1:0]};
    assign access_now  = (state == ST_WAIT) && (cnt == 4'd0) && i_request;
    assign o_busy      = (state != ST_IDLE);

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge i_clock) begin
        if (access_now && rw_q) begin
            mem[idx_q] <= wdat_q;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            rw_q    <= 1'b0;
            idx_q   <= '0;
            wdat_q  <= 32'h0;
            o_data  <= 32'h0;
            o_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_request) begin
                        rw_q   <= i_rw;
                        idx_q  <= i_address[ADDR_WIDTH+1:2];
                        wdat_q <= i_data;
                        cnt    <= 4'(WAIT_STATES);
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!i_request) begin
                        state <= ST_IDLE;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!rw_q) begin
                            o_data <= mem[idx_q];
                        end
                        o_ready <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!i_request) begin
                        o_ready <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Bench for bus_ram_responder: one instance with WAIT_STATES=2, one with WAIT_STATES=0.
module tb_bus_ram_responder;

    logic        clk;
    logic        rst_n;
    logic        req  [2];
    logic        rw   [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic [31:0] rdat [2];
    logic        rdy  [2];
    logic        busy [2];

    int total;
    int bad;

    typedef struct {
        int          d;
        logic        w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp_data;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          lat;
    } sb_t;

    sb_t  sbq [$];
    vec_t vecs [13];

    bus_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_ws2 (
        .i_clock(clk), .i_reset(rst_n), .i_request(req[0]), .i_rw(rw[0]),
        .i_address(addr[0]), .i_data(wdat[0]), .o_data(rdat[0]),
        .o_ready(rdy[0]), .o_busy(busy[0])
    );

    bus_ram_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_ws0 (
        .i_clock(clk), .i_reset(rst_n), .i_request(req[1]), .i_rw(rw[1]),
        .i_address(addr[1]), .i_data(wdat[1]), .o_data(rdat[1]),
        .o_ready(rdy[1]), .o_busy(busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Full handshake; inputs are scrambled after the sampling edge to prove they are latched.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] ex, input int hold);
        sb_t         e;
        sb_t         got;
        int          lat;
        logic [31:0] held;
        lat = 0;
        @(negedge clk);
        req[d]  = 1'b1;
        rw[d]   = w;
        addr[d] = a;
        wdat[d] = wd;
        e.data  = ex;
        e.lat   = (d == 0) ? 4 : 2;
        sbq.push_back(e);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                addr[d] = $urandom;
                wdat[d] = $urandom;
                rw[d]   = ~w;
            end
            if (rdy[d]) begin
                lat = n;
                break;
            end
        end
        got = sbq.pop_front();
        if (lat == 0) begin
            total++;
            bad++;
            $display("FAIL timeout dut=%0d actual=no_ready required=ready", d);
        end else begin
            chk($sformatf("latency d%0d a%h", d, a), 32'(lat), 32'(got.lat));
            chk($sformatf("o_data d%0d a%h", d, a), rdat[d], got.data);
        end
        held = rdat[d];
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk($sformatf("hold_ready c%0d", k), {31'h0, rdy[d]}, 32'h1);
            chk($sformatf("hold_data c%0d", k), rdat[d], held);
        end
        req[d] = 1'b0;
        @(negedge clk);
        chk($sformatf("drop_ready d%0d", d), {31'h0, rdy[d]}, 32'h0);
        chk($sformatf("drop_busy d%0d", d), {31'h0, busy[d]}, 32'h0);
    endtask

    initial begin
        logic seen;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i]  = 1'b0;
            rw[i]   = 1'b0;
            addr[i] = 32'h0;
            wdat[i] = 32'h0;
        end

        vecs[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,        32'hDEADBEEF};
        vecs[2]  = '{0, 1'b1, 32'h0000_1004, 32'h12345678, 32'hDEADBEEF};
        vecs[3]  = '{0, 1'b0, 32'h0000_0004, 32'h0,        32'h12345678};
        vecs[4]  = '{0, 1'b0, 32'h0000_0007, 32'h0,        32'h12345678};
        vecs[5]  = '{0, 1'b1, 32'h0000_0020, 32'h11111111, 32'h12345678};
        vecs[6]  = '{0, 1'b1, 32'h0000_0040, 32'h0,        32'h12345678};
        vecs[7]  = '{0, 1'b0, 32'h0000_0020, 32'h0,        32'h11111111};
        vecs[8]  = '{1, 1'b1, 32'h0000_0008, 32'hA5A5A5A5, 32'h0};
        vecs[9]  = '{1, 1'b1, 32'h0000_000C, 32'h5A5A5A5A, 32'h0};
        vecs[10] = '{1, 1'b0, 32'h0000_0008, 32'h0,        32'hA5A5A5A5};
        vecs[11] = '{1, 1'b0, 32'h0000_000C, 32'h0,        32'h5A5A5A5A};
        vecs[12] = '{1, 1'b0, 32'hFFFF_F00C, 32'h0,        32'h5A5A5A5A};

        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_ready d%0d", i), {31'h0, rdy[i]}, 32'h0);
            chk($sformatf("reset_busy d%0d", i), {31'h0, busy[i]}, 32'h0);
            chk($sformatf("reset_data d%0d", i), rdat[i], 32'h0);
        end
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            access(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].exp_data, 0);
        end

        access(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 10);
        access(0, 1'b0, 32'h0000_0020, 32'h0, 32'h11111111, 0);

        // Abort: request withdrawn while in WAIT.
        @(negedge clk);
        req[0]  = 1'b1;
        rw[0]   = 1'b1;
        addr[0] = 32'h0000_0020;
        wdat[0] = 32'hAAAA5555;
        @(negedge clk);
        req[0] = 1'b0;
        seen   = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rdy[0]) seen = 1'b1;
        end
        chk("abort_no_ready", {31'h0, seen}, 32'h0);
        chk("abort_busy", {31'h0, busy[0]}, 32'h0);
        chk("abort_data", rdat[0], 32'h11111111);
        access(0, 1'b0, 32'h0000_0020, 32'h0, 32'h11111111, 0);

        // Reset in the middle of WAIT cancels the write.
        @(negedge clk);
        req[0]  = 1'b1;
        rw[0]   = 1'b1;
        addr[0] = 32'h0000_0040;
        wdat[0] = 32'hCAFEF00D;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", {31'h0, rdy[0]}, 32'h0);
        chk("rst_mid_data", rdat[0], 32'h0);
        chk("rst_mid_busy", {31'h0, busy[0]}, 32'h0);
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 0);
        access(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEADBEEF, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_ram_responder.md
BUS_RAM_RESPONDER -- requirements
Module: bus_ram_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, number of word-index bits (memory depth 2^ADDR_WIDTH 32-bit words).
REQ-002 Parameter WAIT_STATES, default 2, extra cycles inserted before an access completes (0..15).
REQ-003 i_clock  input  1  single clock; all state changes on rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_request  input  1  initiator request; held high until o_ready seen, then dropped.
REQ-006 i_rw  input  1  access type; 0 = read, 1 = write.
REQ-007 i_address  input  32  byte address; word index = i_address[ADDR_WIDTH+1:2].
REQ-008 i_data  input  32  write data.
REQ-009 o_data  output  32  read data, registered.
REQ-010 o_ready  output  1  access complete, registered.
REQ-011 o_busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Internal storage SHALL be a 2^ADDR_WIDTH x 32 word array; i_address[1:0] and bits above ADDR_WIDTH+1 ignored (aliasing, no error).
REQ-013 State machine SHALL have exactly three states: IDLE, WAIT, DONE.
REQ-014 IDLE: on a rising edge with i_request=1, latch i_rw, word index, i_data; load wait counter with WAIT_STATES; go to WAIT.
REQ-015 WAIT, counter != 0: decrement counter; remain in WAIT.
REQ-016 WAIT, counter == 0: perform access with latched values (write: array[index] <= data; read: o_data <= array[index]); set o_ready=1; go to DONE.
REQ-017 Latency: o_ready SHALL rise exactly WAIT_STATES+2 rising edges after (and counting) the edge that samples the request in IDLE; WAIT_STATES=0 gives 2.
REQ-018 DONE: o_ready and o_data SHALL stay constant while i_request=1.
REQ-019 DONE, i_request=0 at a rising edge: o_ready <= 0; go to IDLE (four-phase handshake).
REQ-020 A new request SHALL NOT be sampled on the same edge that leaves DONE; earliest sample is the following edge.
REQ-021 i_request dropping while in WAIT (protocol violation): abort, no array write, o_data unchanged, o_ready stays 0, go to IDLE next edge.
REQ-022 Changes on i_rw, i_address, i_data after the IDLE sampling edge SHALL have no effect on the in-flight access.
REQ-023 Writes SHALL NOT modify o_data; o_data holds the last read value.
REQ-024 o_busy SHALL be combinational from state (1 in WAIT and DONE).

Reset
REQ-025 i_reset=0 SHALL immediately (asynchronously) force state IDLE, o_ready=0, o_data=32'h0, wait counter=0.
REQ-026 Reset SHALL NOT clear the storage array; contents are undefined after power-up and preserved across reset.
REQ-027 Reset asserted in WAIT SHALL cancel the pending access (no write performed); reset release returns to normal IDLE sampling on the next edge.

Verification
REQ-028 WAIT_STATES=2: write 0xDEADBEEF to 0x0000_0010, then read 0x0000_0010 -> o_ready rises 4 edges after each request sample, read o_data=0xDEADBEEF.
REQ-029 Aliasing, ADDR_WIDTH=10: write 0x12345678 to 0x0000_1004, read 0x0000_0004 and 0x0000_0007 -> both return 0x12345678.
REQ-030 Hold in DONE: keep i_request high 10 cycles after o_ready -> o_ready and o_data stable all 10 cycles; drop request -> o_ready=0 next edge, o_busy=0.
REQ-031 Abort: write 0xAAAA5555 to 0x20 over prior 0x11111111, drop i_request in WAIT -> no o_ready; subsequent read of 0x20 returns 0x11111111.
REQ-032 Reset mid-WAIT during write of 0xCAFEF00D to 0x40 (prior 0x0) -> o_ready=0, o_data=0 immediately; after release, read 0x40 returns 0x0.
REQ-033 Back-to-back with WAIT_STATES=0: re-raise request one edge after leaving DONE -> sampled on that edge, o_ready after 2 edges; changing i_address during WAIT does not alter result.
